// File: rtl/arb_requester.sv
// ============================================================================
// arb_requester : client agent for the two-port registered-grant arbiter
// Revision      : 1.0
// ============================================================================
`default_nettype none

module arb_requester #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             xfer_en,
  output logic             xfer_last,
  output logic             done,
  output logic             timeout_err,
  output logic             lost_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    REL  = 2'd3
  } state_t;

  localparam logic [TO_W-1:0]  WAIT_MAX = TO_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] ONE_BEAT = LEN_W'(1);
  localparam logic [LEN_W-1:0] TWO_BEAT = LEN_W'(2);

  state_t           state;
  logic [LEN_W-1:0] beats;
  logic [TO_W-1:0]  wait_cnt;
  logic             completed;  // remembers a clean finish so REL knows whether to pulse done

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      beats       <= '0;
      wait_cnt    <= '0;
      completed   <= 1'b0;
      req         <= 1'b0;
      xfer_en     <= 1'b0;
      xfer_last   <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      lost_err    <= 1'b0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      lost_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            beats     <= cmd_len;
            completed <= 1'b0;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state    <= REQ;
              req      <= 1'b1;
              wait_cnt <= '0;
            end
          end
        end
        REQ: begin
          // A grant on the timeout edge takes priority over the abort.
          if (gnt) begin
            state     <= OWN;
            xfer_en   <= 1'b1;
            xfer_last <= (beats == ONE_BEAT);
          end else if (wait_cnt == WAIT_MAX) begin
            state       <= REL;
            req         <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        OWN: begin
          if (xfer_en) begin
            if (!gnt) begin
              state     <= REL;
              req       <= 1'b0;
              xfer_en   <= 1'b0;
              xfer_last <= 1'b0;
              lost_err  <= 1'b1;
            end else if (beats == ONE_BEAT) begin
              state     <= REL;
              req       <= 1'b0;
              xfer_en   <= 1'b0;
              xfer_last <= 1'b0;
              completed <= 1'b1;
            end else begin
              beats     <= beats - ONE_BEAT;
              xfer_last <= (beats == TWO_BEAT);
            end
          end
        end
        REL: begin
          if (!gnt) begin
            state     <= IDLE;
            done      <= completed;
            completed <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arb_requester.sv
// ============================================================================
// tb_arb_requester : two requesters around a small registered-grant arbiter
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_arb_requester;

  logic       clock;
  logic       reset_n;
  logic       cmd_valid0, cmd_valid1;
  logic [3:0] cmd_len0, cmd_len1;
  logic       cmd_ready0, cmd_ready1;
  logic       req0, req1;
  logic       arb_gnt0, arb_gnt1;
  logic       kill0;
  logic       gnt0, gnt1;
  logic       xfer_en0, xfer_en1, xfer_last0, xfer_last1;
  logic       done0, done1, timeout_err0, timeout_err1, lost_err0, lost_err1;
  logic       busy0, busy1;

  int compared   = 0;
  int mismatched = 0;

  assign gnt0 = arb_gnt0 & ~kill0;
  assign gnt1 = arb_gnt1;

  arb_requester dut0 (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid0), .cmd_len(cmd_len0),
    .cmd_ready(cmd_ready0), .req(req0), .gnt(gnt0), .xfer_en(xfer_en0),
    .xfer_last(xfer_last0), .done(done0), .timeout_err(timeout_err0),
    .lost_err(lost_err0), .busy(busy0)
  );

  arb_requester dut1 (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_len(cmd_len1),
    .cmd_ready(cmd_ready1), .req(req1), .gnt(gnt1), .xfer_en(xfer_en1),
    .xfer_last(xfer_last1), .done(done1), .timeout_err(timeout_err1),
    .lost_err(lost_err1), .busy(busy1)
  );

  // Arbiter: holds a grant while its request stays high, port 0 wins ties.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      arb_gnt0 <= 1'b0;
      arb_gnt1 <= 1'b0;
    end else if (arb_gnt0) begin
      arb_gnt0 <= req0;
    end else if (arb_gnt1) begin
      arb_gnt1 <= req1;
    end else if (req0) begin
      arb_gnt0 <= 1'b1;
    end else if (req1) begin
      arb_gnt1 <= 1'b1;
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // {req, xfer_en, xfer_last, done, cmd_ready}
  logic [4:0] exp_burst [9]  = '{5'b10000, 5'b10000, 5'b11000, 5'b11000, 5'b11100,
                                 5'b00000, 5'b00000, 5'b00011, 5'b00001};
  // {req, xfer_en, done, timeout_err, cmd_ready}
  logic [4:0] exp_to_mid     = 5'b10000;
  logic [4:0] exp_to_fire    = 5'b00010;
  logic [4:0] exp_to_end     = 5'b00001;
  // {req, xfer_en, done, lost_err, cmd_ready}
  logic [4:0] exp_loss [8]   = '{5'b10000, 5'b10000, 5'b11000, 5'b11000, 5'b11000,
                                 5'b00010, 5'b00001, 5'b00001};
  // {xfer_en0, xfer_en1, done0, done1}
  logic [3:0] exp_cont [16]  = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                 4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0100,
                                 4'b0000, 4'b0000, 4'b0001, 4'b0000};
  // {req, xfer_en, xfer_last, done, cmd_ready}
  logic [4:0] exp_fresh [7]  = '{5'b10000, 5'b10000, 5'b11100, 5'b00000, 5'b00000,
                                 5'b00011, 5'b00001};

  initial begin
    reset_n    = 1'b0;
    cmd_valid0 = 1'b0;
    cmd_valid1 = 1'b0;
    cmd_len0   = 4'd0;
    cmd_len1   = 4'd0;
    kill0      = 1'b0;
    tick();
    tick();
    chk("reset_state", {1'b0, req0, xfer_en0, xfer_last0, done0, timeout_err0, lost_err0,
                        busy0 | ~cmd_ready0}, 8'h00);
    reset_n = 1'b1;
    tick();

    // Single burst of 3 beats with an idle arbiter.
    cmd_valid0 = 1'b1;
    cmd_len0   = 4'd3;
    for (int e = 0; e < 9; e++) begin
      tick();
      if (e == 0) cmd_valid0 = 1'b0;
      chk($sformatf("burst_e%0d", e), {3'b0, req0, xfer_en0, xfer_last0, done0, cmd_ready0},
          {3'b0, exp_burst[e]});
    end

    // Zero-length command completes without ever requesting.
    cmd_valid0 = 1'b1;
    cmd_len0   = 4'd0;
    tick();
    cmd_valid0 = 1'b0;
    chk("zero_e0", {2'b0, busy0, req0, xfer_en0, xfer_last0, done0, cmd_ready0}, 8'b00000011);
    tick();
    chk("zero_e1", {2'b0, busy0, req0, xfer_en0, xfer_last0, done0, cmd_ready0}, 8'b00000001);

    // Grant-wait timeout with the grant held low.
    kill0      = 1'b1;
    cmd_valid0 = 1'b1;
    cmd_len0   = 4'd4;
    for (int e = 0; e < 17; e++) begin
      tick();
      if (e == 0) cmd_valid0 = 1'b0;
      chk($sformatf("timeout_e%0d", e), {3'b0, req0, xfer_en0, done0, timeout_err0, cmd_ready0},
          {3'b0, (e < 15) ? exp_to_mid : ((e == 15) ? exp_to_fire : exp_to_end)});
    end
    kill0 = 1'b0;
    tick();
    tick();

    // Grant lost while the third of six beats is on the bus.
    cmd_valid0 = 1'b1;
    cmd_len0   = 4'd6;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 0) cmd_valid0 = 1'b0;
      chk($sformatf("loss_e%0d", e), {3'b0, req0, xfer_en0, done0, lost_err0, cmd_ready0},
          {3'b0, exp_loss[e]});
      if (e == 4) kill0 = 1'b1;
    end
    kill0 = 1'b0;
    tick();
    tick();

    // Contention: port 0 bursts 5 beats, port 1 asks for 2 one cycle later.
    cmd_valid0 = 1'b1;
    cmd_len0   = 4'd5;
    for (int e = 0; e < 16; e++) begin
      tick();
      if (e == 0) begin
        cmd_valid0 = 1'b0;
        cmd_valid1 = 1'b1;
        cmd_len1   = 4'd2;
      end
      if (e == 1) cmd_valid1 = 1'b0;
      chk($sformatf("cont_e%0d", e), {4'b0, xfer_en0, xfer_en1, done0, done1},
          {4'b0, exp_cont[e]});
      chk($sformatf("mutex_e%0d", e), {7'b0, xfer_en0 & xfer_en1}, 8'h00);
    end

    // Reset asserted between edges during beat 2, then a fresh 1-beat command.
    cmd_valid0 = 1'b1;
    cmd_len0   = 4'd4;
    tick();
    cmd_valid0 = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_reset", {4'b0, req0, xfer_en0, busy0, cmd_ready0}, 8'b00001110);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", {4'b0, req0, xfer_en0, busy0, cmd_ready0}, 8'b00000001);
    tick();
    reset_n = 1'b1;
    tick();
    cmd_valid0 = 1'b1;
    cmd_len0   = 4'd1;
    for (int e = 0; e < 7; e++) begin
      tick();
      if (e == 0) cmd_valid0 = 1'b0;
      chk($sformatf("fresh_e%0d", e), {3'b0, req0, xfer_en0, xfer_last0, done0, cmd_ready0},
          {3'b0, exp_fresh[e]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
